// File: rtl/shift_serializer.sv
// rtl/shift_serializer.sv - parallel-in, serial-out transmitter with valid/ready on both sides
module shift_serializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             w_accept;
  logic             w_beat;
  logic             w_last;

  assign w_last   = (r_state == S_SEND) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = in_valid & in_ready;
  assign w_beat   = ser_valid & ser_ready;
  assign ser_out  = r_dir ? r_sreg[0] : r_sreg[WIDTH-1];
  assign ser_last = w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A new word may only enter on the final beat, so the next word follows with no bubble.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) begin
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        ser_valid = 1'b1;
        in_ready  = ~rst & w_last & ser_ready;
        if (w_last && ser_ready && !in_valid) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
    end else if (w_accept) begin
      r_sreg <= in_data;
      r_dir  <= in_dir;
      r_cnt  <= '0;
    end else if (w_beat) begin
      r_sreg <= r_dir ? (r_sreg >> 1) : (r_sreg << 1);
      r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
